// File: rtl/cpu_pkg.sv
// Shared constants and types for the core_cpu front end:
// instruction word layout, reserved words and the fetch sequencer states.
package cpu_pkg;

    localparam int OPCODE_W  = 4;
    localparam int OPERAND_W = 16;
    localparam int INSTR_W   = OPCODE_W + OPERAND_W;

    localparam logic [OPCODE_W-1:0] HALT_OP  = 4'hF;
    localparam logic [INSTR_W-1:0]  NOP_WORD = 20'h00000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GAP   = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/prog_mem.sv
// Program store: register array, synchronous write, asynchronous read,
// cleared by reset so a reset always leaves an all-NOP program behind.
module prog_mem
    import cpu_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               we_i,
    input  logic [AW-1:0]      waddr_i,
    input  logic [INSTR_W-1:0] wdata_i,
    input  logic [AW-1:0]      raddr_i,
    output logic [INSTR_W-1:0] rdata_o
);

    logic [INSTR_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/instr_fetch_unit.sv
// Issue sequencer for core_cpu: plays the stored program one word at a time,
// padding each word with NOP cycles, and stops at length, HALT or abort.
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter int                   DEPTH     = 16,
    parameter int                   AW        = 4,
    parameter int                   ISSUE_GAP = 2,
    parameter logic [INSTR_W-1:0]   NOP_WORD  = cpu_pkg::NOP_WORD,
    parameter logic [OPCODE_W-1:0]  HALT_OP   = cpu_pkg::HALT_OP
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_en,
    input  logic [AW-1:0]      wr_addr,
    input  logic [INSTR_W-1:0] wr_data,
    input  logic               start,
    input  logic               stop,
    input  logic [AW:0]        prog_len,
    output logic [INSTR_W-1:0] instr_out,
    output logic               instr_valid,
    output logic [AW-1:0]      pc,
    output logic               busy,
    output logic               done,
    output logic               wr_err
);

    localparam int             GW       = (ISSUE_GAP > 1) ? $clog2(ISSUE_GAP) : 1;
    localparam logic [GW-1:0]  GAP_INIT = GW'((ISSUE_GAP > 0) ? ISSUE_GAP - 1 : 0);
    localparam logic [AW:0]    DEPTH_L  = (AW+1)'(DEPTH);
    localparam logic [AW:0]    LEN_ONE  = (AW+1)'(1);

    fetch_state_e       state_q, state_d;
    logic [AW-1:0]      pc_q, pc_d;
    logic [AW:0]        len_q, len_d;
    logic [GW-1:0]      gap_q, gap_d;
    logic               last_q, last_d;
    logic               finish_q, finish_d;

    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               wr_err_q, wr_err_d;
    logic [AW-1:0]      pc_out_q;

    logic               mem_we;
    logic [INSTR_W-1:0] rd_word;
    logic               start_ok;
    logic               halt_w;
    logic               is_last;
    logic [AW:0]        len_sel;

    prog_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_prog_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (mem_we),
        .waddr_i (wr_addr),
        .wdata_i (wr_data),
        .raddr_i (pc_q),
        .rdata_o (rd_word)
    );

    // stop outranks start, and a start is only honoured from IDLE
    assign start_ok = start && !stop && (state_q == IDLE);
    assign len_sel  = (prog_len > DEPTH_L) ? DEPTH_L : prog_len;
    assign halt_w   = (rd_word[INSTR_W-1 -: OPCODE_W] == HALT_OP);
    assign is_last  = ({1'b0, pc_q} == (len_q - LEN_ONE));

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        len_d    = len_q;
        gap_d    = gap_q;
        last_d   = last_q;
        finish_d = 1'b0;
        mem_we   = 1'b0;
        instr_d  = NOP_WORD;
        valid_d  = 1'b0;
        busy_d   = 1'b0;
        done_d   = finish_q;
        wr_err_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start_ok) begin
                    len_d  = len_sel;
                    pc_d   = '0;
                    last_d = 1'b0;
                    if (len_sel == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ISSUE;
                    end
                end
                if (wr_en) begin
                    if (start_ok) begin
                        wr_err_d = 1'b1;
                    end else begin
                        mem_we = 1'b1;
                    end
                end
            end
            ISSUE: begin
                wr_err_d = wr_en;
                if (stop) begin
                    state_d = IDLE;
                end else if (halt_w) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    instr_d = rd_word;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                    last_d  = is_last;
                    if (ISSUE_GAP == 0) begin
                        if (is_last) begin
                            state_d  = IDLE;
                            finish_d = 1'b1;
                        end else begin
                            pc_d = pc_q + AW'(1);
                        end
                    end else begin
                        state_d = GAP;
                        gap_d   = GAP_INIT;
                    end
                end
            end
            GAP: begin
                wr_err_d = wr_en;
                if (stop) begin
                    state_d = IDLE;
                end else begin
                    busy_d = 1'b1;
                    if (gap_q == '0) begin
                        // done is deferred one cycle so it lands after the last NOP
                        if (last_q) begin
                            state_d  = IDLE;
                            finish_d = 1'b1;
                        end else begin
                            pc_d    = pc_q + AW'(1);
                            state_d = ISSUE;
                        end
                    end else begin
                        gap_d = gap_q - GW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            pc_q     <= '0;
            len_q    <= '0;
            gap_q    <= '0;
            last_q   <= 1'b0;
            finish_q <= 1'b0;
            instr_q  <= NOP_WORD;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            wr_err_q <= 1'b0;
            pc_out_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            len_q    <= len_d;
            gap_q    <= gap_d;
            last_q   <= last_d;
            finish_q <= finish_d;
            instr_q  <= instr_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            wr_err_q <= wr_err_d;
            pc_out_q <= pc_q;
        end
    end

    assign instr_out   = instr_q;
    assign instr_valid = valid_q;
    assign pc          = pc_out_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign wr_err      = wr_err_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios with literal timing checks,
// then random traffic, all scored cycle by cycle against an offset-based model.
module tb_instr_fetch_unit;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int GAPN  = 2;
    localparam int P     = GAPN + 1;
    localparam logic [19:0] NOP = 20'h00000;
    localparam logic [59:0] NORMAL_WORDS = 60'h100052000330000;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [19:0]   wr_data;
    logic          start;
    logic          stop;
    logic [AW:0]   prog_len;
    logic [19:0]   instr_out;
    logic          instr_valid;
    logic [AW-1:0] pc;
    logic          busy;
    logic          done;
    logic          wr_err;

    instr_fetch_unit #(
        .DEPTH     (DEPTH),
        .AW        (AW),
        .ISSUE_GAP (GAPN)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .start       (start),
        .stop        (stop),
        .prog_len    (prog_len),
        .instr_out   (instr_out),
        .instr_valid (instr_valid),
        .pc          (pc),
        .busy        (busy),
        .done        (done),
        .wr_err      (wr_err)
    );

    int checks = 0;
    int failures = 0;

    task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // A run accepted at edge t is described by offsets d = edge - t:
    // word i shows at d = 1 + i*P, busy covers d = 1..run_dend, done shows at run_done_d.
    logic [19:0] mem_m [DEPTH];
    bit          run_on;
    int          run_t, run_dend, run_done_d;
    int          edge_n;
    logic [19:0] exp_instr;
    bit          exp_valid, exp_busy, exp_done, exp_werr;
    int          exp_pc;

    task automatic model_reset();
        run_on = 1'b0;
        for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    endtask

    task automatic model_step();
        int d, n, k;
        bit active, acc;
        edge_n++;
        exp_instr = NOP;
        exp_valid = 1'b0;
        exp_busy  = 1'b0;
        exp_done  = 1'b0;
        exp_werr  = 1'b0;
        exp_pc    = 0;
        d = edge_n - run_t;
        active = run_on && (d >= 1) && (d <= run_dend);
        if (run_on) begin
            if (active && stop) begin
                run_on = 1'b0;
            end else if (d == run_done_d) begin
                exp_done = 1'b1;
                run_on = 1'b0;
            end else if (active) begin
                exp_busy = 1'b1;
                if ((d - 1) % P == 0) begin
                    exp_valid = 1'b1;
                    exp_pc    = (d - 1) / P;
                    exp_instr = mem_m[exp_pc];
                end
            end
        end
        acc = start && !stop && !active;
        if (wr_en) begin
            if (active || acc) exp_werr = 1'b1;
            else mem_m[wr_addr] = wr_data;
        end
        if (acc) begin
            n = (prog_len > DEPTH) ? DEPTH : int'(prog_len);
            if (n == 0) begin
                exp_done = 1'b1;
            end else begin
                k = -1;
                for (int i = 0; i < n; i++) begin
                    if (k < 0 && mem_m[i][19:16] == 4'hF) k = i;
                end
                run_on = 1'b1;
                run_t  = edge_n;
                if (k >= 0) begin
                    run_dend   = k * P + 1;
                    run_done_d = k * P + 1;
                end else begin
                    run_dend   = n * P;
                    run_done_d = n * P + 1;
                end
            end
        end
    endtask

    // ---------------- scoreboard: every cycle out of reset ----------------
    always @(posedge clk) begin
        if (rst_n) begin
            model_step();
            #1;
            if (rst_n) begin
                check_val("instr_out", 64'(instr_out), 64'(exp_instr));
                check_val("instr_valid", 64'(instr_valid), 64'(exp_valid));
                check_val("busy", 64'(busy), 64'(exp_busy));
                check_val("done", 64'(done), 64'(exp_done));
                check_val("wr_err", 64'(wr_err), 64'(exp_werr));
                if (exp_valid) check_val("pc", 64'(pc), 64'(exp_pc));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic clear_inputs();
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        start = 1'b0; stop = 1'b0; prog_len = '0;
    endtask

    task automatic drive(input bit we, input logic [AW-1:0] wa, input logic [19:0] wd,
                         input bit st, input bit sp, input logic [AW:0] pl);
        @(negedge clk);
        wr_en = we; wr_addr = wa; wr_data = wd;
        start = st; stop = sp; prog_len = pl;
    endtask

    task automatic write_word(input logic [AW-1:0] a, input logic [19:0] w);
        drive(1'b1, a, w, 1'b0, 1'b0, '0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0, '0, 1'b0, 1'b0, '0);
    endtask

    // Starts a run and records, per offset from the start edge, valid/done/busy and issued words.
    task automatic timed_run(input logic [AW:0] pl, input int span,
                             output logic [63:0] vm, output logic [63:0] dm,
                             output logic [63:0] bm, output logic [59:0] wc);
        vm = '0; dm = '0; bm = '0; wc = '0;
        drive(1'b0, '0, '0, 1'b1, 1'b0, pl);
        @(posedge clk); #2;
        clear_inputs();
        for (int off = 0; off <= span; off++) begin
            if (off > 0) begin
                @(posedge clk); #2;
            end
            if (instr_valid) begin
                vm[off] = 1'b1;
                wc = {wc[39:0], instr_out};
            end
            if (done) dm[off] = 1'b1;
            if (busy) bm[off] = 1'b1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    // ---------------- directed + random stimulus ----------------
    initial begin
        logic [63:0] vm, dm, bm;
        logic [59:0] wc;
        int done_seen;
        clear_inputs();
        model_reset();
        edge_n = 0;
        run_t = 0; run_dend = 0; run_done_d = 0;

        #3;
        check_val("reset_instr", 64'(instr_out), 64'(NOP));
        check_val("reset_valid", 64'(instr_valid), 64'd0);
        check_val("reset_busy", 64'(busy), 64'd0);
        check_val("reset_done", 64'(done), 64'd0);
        check_val("reset_wr_err", 64'(wr_err), 64'd0);
        check_val("reset_pc", 64'(pc), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // normal run
        write_word(4'd0, 20'h10005);
        write_word(4'd1, 20'h20003);
        write_word(4'd2, 20'h30000);
        timed_run(5'd3, 12, vm, dm, bm, wc);
        check_val("normal_valid_offsets", vm, 64'h92);
        check_val("normal_done_offset", dm, 64'h400);
        check_val("normal_busy_offsets", bm, 64'h3FE);
        check_val("normal_words", 64'(wc), 64'(NORMAL_WORDS));

        // HALT at word 1
        write_word(4'd1, 20'hF0000);
        timed_run(5'd3, 12, vm, dm, bm, wc);
        check_val("halt_valid_offsets", vm, 64'h2);
        check_val("halt_done_offset", dm, 64'h10);
        check_val("halt_busy_offsets", bm, 64'hE);
        check_val("halt_words", 64'(wc), 64'h10005);

        // zero length
        timed_run(5'd0, 6, vm, dm, bm, wc);
        check_val("zero_valid", vm, 64'h0);
        check_val("zero_done_offset", dm, 64'h1);
        check_val("zero_busy", bm, 64'h0);

        // write while busy, then read back
        write_word(4'd1, 20'h20003);
        drive(1'b0, '0, '0, 1'b1, 1'b0, 5'd3);
        drive(1'b1, 4'd0, 20'hAAAAA, 1'b0, 1'b0, '0);
        @(posedge clk); #2;
        check_val("busy_write_err", 64'(wr_err), 64'd1);
        clear_inputs();
        idle(12);
        timed_run(5'd3, 12, vm, dm, bm, wc);
        check_val("readback_words", 64'(wc), 64'(NORMAL_WORDS));

        // abort in the gap after word 1
        drive(1'b0, '0, '0, 1'b1, 1'b0, 5'd3);
        idle(5);
        drive(1'b0, '0, '0, 1'b0, 1'b1, '0);
        @(posedge clk); #2;
        check_val("abort_busy", 64'(busy), 64'd0);
        check_val("abort_valid", 64'(instr_valid), 64'd0);
        check_val("abort_instr", 64'(instr_out), 64'(NOP));
        clear_inputs();
        done_seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #2;
            if (done) done_seen++;
        end
        check_val("abort_no_done", 64'(done_seen), 64'd0);
        timed_run(5'd3, 12, vm, dm, bm, wc);
        check_val("restart_valid_offsets", vm, 64'h92);
        check_val("restart_words", 64'(wc), 64'(NORMAL_WORDS));

        // overlong length runs exactly DEPTH words
        for (int i = 0; i < DEPTH; i++) begin
            write_word(AW'(i), {4'($urandom_range(0, 14)), 16'($urandom)});
        end
        timed_run(5'd20, 52, vm, dm, bm, wc);
        check_val("overlong_word_count", 64'($countones(vm)), 64'd16);
        check_val("overlong_done_offset", dm, 64'h1 << 49);

        // asynchronous reset mid-run
        drive(1'b0, '0, '0, 1'b1, 1'b0, 5'd16);
        idle(6);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_val("midreset_instr", 64'(instr_out), 64'(NOP));
        check_val("midreset_valid", 64'(instr_valid), 64'd0);
        check_val("midreset_busy", 64'(busy), 64'd0);
        check_val("midreset_done", 64'(done), 64'd0);
        check_val("midreset_pc", 64'(pc), 64'd0);
        model_reset();
        clear_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        timed_run(5'd3, 12, vm, dm, bm, wc);
        check_val("postreset_valid_offsets", vm, 64'h92);
        check_val("postreset_words", 64'(wc), 64'h0);
        check_val("postreset_done_offset", dm, 64'h400);

        // random traffic
        for (int i = 0; i < 800; i++) begin
            drive(($urandom_range(0, 3) == 0), AW'($urandom_range(0, DEPTH - 1)),
                  {4'($urandom_range(0, 15)), 16'($urandom)},
                  ($urandom_range(0, 7) == 0), ($urandom_range(0, 29) == 0),
                  5'($urandom_range(0, 20)));
        end
        idle(60);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
